// File: rtl/mux2_arbiter_if.sv
// mux2_arbiter_if: requester, output and grant signals of the two-input burst arbiter.
// The master side drives the requesters and out_ready; the slave side is the arbiter.
interface mux2_arbiter_if #(
  parameter int LEN = 8
);
  logic           in0_valid;
  logic [LEN-1:0] in0_data;
  logic           in0_last;
  logic           in0_ready;
  logic           in1_valid;
  logic [LEN-1:0] in1_data;
  logic           in1_last;
  logic           in1_ready;
  logic           out_valid;
  logic [LEN-1:0] out_data;
  logic           out_last;
  logic           out_ready;
  logic           sel;
  logic [1:0]     grant;

  modport master (
    output in0_valid, in0_data, in0_last,
    output in1_valid, in1_data, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_last,
    input  sel, grant
  );

  modport slave (
    input  in0_valid, in0_data, in0_last,
    input  in1_valid, in1_data, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_last,
    output sel, grant
  );
endinterface

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester arbiter with a registered output beat.
// Contention from IDLE goes to the requester not granted last; in0 wins first after reset.
// Optional feature: define MUX2_ARBITER_LOCK_EN to hold a grant until a beat with last=1
// transfers. Without it every transferred beat ends the grant.
module mux2_arbiter #(
  parameter int LEN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mux2_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic           r_last_grant;
  logic           r_out_valid;
  logic           r_out_last;
  logic [LEN-1:0] r_out_data;

  logic w_out_free;
  logic w_xfer0;
  logic w_xfer1;
  logic w_end_grant;

  // Transfer qualifiers: output slot free, granted requester valid.
  always_comb begin
    w_out_free = !r_out_valid || io_bus.out_ready;
    w_xfer0    = (r_state == StG0) && io_bus.in0_valid && w_out_free;
    w_xfer1    = (r_state == StG1) && io_bus.in1_valid && w_out_free;
`ifdef MUX2_ARBITER_LOCK_EN
    w_end_grant = (w_xfer0 && io_bus.in0_last) || (w_xfer1 && io_bus.in1_last);
`else
    w_end_grant = w_xfer0 || w_xfer1;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: a grant only moves when it ends; otherwise it holds even with valid low.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (io_bus.in0_valid && io_bus.in1_valid) begin
          w_state_next = r_last_grant ? StG0 : StG1;
        end else if (io_bus.in0_valid) begin
          w_state_next = StG0;
        end else if (io_bus.in1_valid) begin
          w_state_next = StG1;
        end
      end
      StG0: begin
        if (w_end_grant) begin
          if (io_bus.in1_valid)       w_state_next = StG1;
          else if (!io_bus.in0_valid) w_state_next = StIdle;
        end
      end
      StG1: begin
        if (w_end_grant) begin
          if (io_bus.in0_valid)       w_state_next = StG0;
          else if (!io_bus.in1_valid) w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from the state: grant, datapath select and requester readies.
  always_comb begin
    io_bus.grant     = 2'b00;
    io_bus.sel       = 1'b0;
    io_bus.in0_ready = 1'b0;
    io_bus.in1_ready = 1'b0;
    unique case (r_state)
      StG0: begin
        io_bus.grant     = 2'b01;
        io_bus.in0_ready = w_out_free;
      end
      StG1: begin
        io_bus.grant     = 2'b10;
        io_bus.sel       = 1'b1;
        io_bus.in1_ready = w_out_free;
      end
      default: ;
    endcase
  end

  // Output beat register and last-grant memory; data/last hold once the beat drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_xfer0) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= io_bus.in0_data;
      r_out_last   <= io_bus.in0_last;
      r_last_grant <= 1'b0;
    end else if (w_xfer1) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= io_bus.in1_data;
      r_out_last   <= io_bus.in1_last;
      r_last_grant <= 1'b1;
    end else if (r_out_valid && io_bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_last  = r_out_last;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed scenarios plus a random phase against a behavioural model.
module tb_mux2_arbiter;
  localparam int LEN = 8;
`ifdef MUX2_ARBITER_LOCK_EN
  localparam bit Lock = 1'b1;
`else
  localparam bit Lock = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux2_arbiter_if #(.LEN(LEN)) bus ();
  mux2_arbiter #(.LEN(LEN)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Pending beats per requester as {last, data}; head is presented until accepted.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit         gap0;

  // Reference model: owner -1 = nobody, 0/1 = requester holding the grant.
  int         m_owner;
  int         m_lastg;
  bit         m_ov;
  bit         m_ol;
  logic [7:0] m_od;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_lastg = 1;
    m_ov    = 1'b0;
    m_ol    = 1'b0;
    m_od    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_ready", {bus.in1_ready, bus.in0_ready}, 0);
    q0.delete();
    q1.delete();
    got.delete();
    gap0 = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, compare, then advance the model past the next rise.
  task automatic cycle(input bit ordy);
    bit         v0, v1, x0, x1, free, vo, vs;
    logic [8:0] beat;
    logic [1:0] eg;
    @(negedge clk);
    v0 = (q0.size() > 0) && !gap0;
    v1 = (q1.size() > 0);
    bus.in0_valid = v0;
    bus.in0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.in0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
    bus.in1_valid = v1;
    bus.in1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    bus.in1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    bus.out_ready = ordy;
    #1;
    free = !m_ov || ordy;
    eg   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    chk("grant", bus.grant, eg);
    chk("sel", bus.sel, (m_owner == 1));
    chk("in0_ready", bus.in0_ready, (m_owner == 0) && free);
    chk("in1_ready", bus.in1_ready, (m_owner == 1) && free);
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_data", bus.out_data, m_od);
    chk("out_last", bus.out_last, m_ol);
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);

    x0   = (m_owner == 0) && free && v0;
    x1   = (m_owner == 1) && free && v1;
    beat = '0;
    if (x0 || x1) begin
      beat    = x0 ? q0.pop_front() : q1.pop_front();
      m_od    = beat[7:0];
      m_ol    = beat[8];
      m_ov    = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (m_owner < 0) begin
      if (v0 && v1)  m_owner = (m_lastg == 1) ? 0 : 1;
      else if (v0)   m_owner = 0;
      else if (v1)   m_owner = 1;
    end else if ((x0 || x1) && (!Lock || beat[8])) begin
      vo = (m_owner == 0) ? v1 : v0;
      vs = (m_owner == 0) ? v0 : v1;
      if (vo)       m_owner = 1 - m_owner;
      else if (!vs) m_owner = -1;
    end
    if (x0) m_lastg = 0;
    if (x1) m_lastg = 1;
  endtask

  task automatic compare_seq(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({tag, "_beat"}, got[i], exp_q[i]);
    end
  endtask

  // Runs until n_exp beats leave the output or the cycle budget expires.
  task automatic run(input string tag, input int max_c, input int n_exp,
                     input int st_lo, input int st_hi, input int gp_lo, input int gp_hi,
                     input logic [7:0] hold);
    for (int c = 0; c < max_c; c++) begin
      if (n_exp >= 0 && got.size() >= n_exp) break;
      gap0 = (c >= gp_lo) && (c < gp_hi);
      cycle(!((c >= st_lo) && (c < st_hi)));
      if ((c >= st_lo) && (c < st_hi)) begin
        chk("bp_hold", bus.out_data, hold);
        chk("bp_ready", {bus.in1_ready, bus.in0_ready}, 0);
      end
      if (gap0) chk("gap_grant", bus.grant, 2'b01);
    end
    gap0 = 1'b0;
    if (n_exp >= 0) compare_seq(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in0_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in0_last  = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in1_data  = '0;
    bus.in1_last  = 1'b0;
    bus.out_ready = 1'b0;
    gap0          = 1'b0;
    do_reset();

    // Single requester on in1, three-beat burst.
    q1.push_back({1'b0, 8'h11});
    q1.push_back({1'b0, 8'h22});
    q1.push_back({1'b1, 8'h33});
    exp_q = '{8'h11, 8'h22, 8'h33};
    run("single", 20, 3, -1, -1, -1, -1, 8'h00);

    // Backpressure: output stalled three cycles while holding 0x5A.
    do_reset();
    q0.push_back({1'b0, 8'h5A});
    q0.push_back({1'b1, 8'h6B});
    exp_q = '{8'h5A, 8'h6B};
    run("backpressure", 20, 2, 2, 5, -1, -1, 8'h5A);

    // Reset while a beat sits in the output register, then contention from IDLE.
    do_reset();
    q0.push_back({1'b0, 8'h77});
    q0.push_back({1'b1, 8'h78});
    run("pre_reset", 2, -1, -1, -1, -1, -1, 8'h00);
    @(negedge clk);
    #2;
    chk("pre_rst_valid", bus.out_valid, 1);
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 8'hA0 + 8'(i)});
    for (int i = 0; i < 2; i++) q1.push_back({(i == 1), 8'hB0 + 8'(i)});
`ifdef MUX2_ARBITER_LOCK_EN
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};
`else
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hA3};
`endif
    run("contention", 40, 6, -1, -1, -1, -1, 8'h00);

    // in0 drops valid for two cycles while in1 waits.
    do_reset();
    q0.push_back({1'b0, 8'hC0});
    q0.push_back({1'b0, 8'hC1});
    q0.push_back({1'b1, 8'hC2});
    q1.push_back({1'b1, 8'hD0});
`ifdef MUX2_ARBITER_LOCK_EN
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hD0};
`else
    exp_q = '{8'hC0, 8'hD0, 8'hC1, 8'hC2};
`endif
    run("valid_gap", 40, 4, -1, -1, 3, 5, 8'h00);

    // Random traffic and backpressure against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (q0.size() == 0 && ($urandom % 3) == 0) q0.push_back({($urandom % 3) == 0, 8'($urandom)});
      if (q1.size() == 0 && ($urandom % 3) == 0) q1.push_back({($urandom % 3) == 0, 8'($urandom)});
      cycle(($urandom % 4) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
